thresholding_cfg_loader: RTL and testbench

- AXI4-Lite initiator that programs a thresholding_axi instance's threshold memory from an AXI4-Stream of threshold values.
- Sits between a parameter source (DMA or ROM streamer) and the s_axilite port of the thresholding core.
- Generates the core's address map (channel fold, PE, threshold index) and sequences write, response and optional readback per word.
- Replaces testbench-style fork/join configuration with synthesizable hardware.

---
 rtl/thresholding_cfg_pkg.sv | 36 +++
 rtl/thresholding_cfg_addr_gen.sv | 63 ++++++
 rtl/thresholding_cfg_loader.sv | 210 +++++++++++++++++++++
 tb/tb_thresholding_cfg_loader.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/thresholding_cfg_pkg.sv
`default_nettype none
// thresholding_cfg_pkg: shared FSM states, AXI response code and address composition for the loader.
// Revision: 1.0
package thresholding_cfg_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_WRITE  = 3'd2,
      ST_RESP   = 3'd3,
      ST_VERIFY = 3'd4,
      ST_DONE   = 3'd5
   } state_t;

   localparam logic [1:0] c_OKAY = 2'b00;

   // Word address {cf, pe, t}; fields collapse to nothing when their count is 1.
   function automatic logic [31:0] compose_addr(
      input int cf,
      input int pe,
      input int t,
      input int n_bits,
      input int pe_cnt,
      input int cf_cnt
   );
      int pe_bits;
      logic [31:0] word;
      pe_bits = (pe_cnt > 1) ? $clog2(pe_cnt) : 0;
      word    = 32'(t);
      if (pe_cnt > 1) word = word | (32'(pe) << n_bits);
      if (cf_cnt > 1) word = word | (32'(cf) << (n_bits + pe_bits));
      return word;
   endfunction

endpackage
`default_nettype wire

// File: rtl/thresholding_cfg_addr_gen.sv
`default_nettype none
// thresholding_cfg_addr_gen: t -> pe -> cf counter chain producing the core's threshold word address.
// Revision: 1.0
module thresholding_cfg_addr_gen
   import thresholding_cfg_pkg::*;
#(
   parameter int N         = 4,
   parameter int PE        = 2,
   parameter int CF        = 3,
   parameter int WORD_BITS = 7
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_clear,
   input  logic                 i_advance,
   output logic                 o_last,
   output logic [WORD_BITS-1:0] o_addr
);

   localparam int PE_W = (PE > 1) ? $clog2(PE) : 1;
   localparam int CF_W = (CF > 1) ? $clog2(CF) : 1;

   localparam logic [N-1:0]    c_T_LAST  = N'((1 << N) - 2);
   localparam logic [PE_W-1:0] c_PE_LAST = PE_W'(PE - 1);
   localparam logic [CF_W-1:0] c_CF_LAST = CF_W'(CF - 1);

   logic [N-1:0]    r_t;
   logic [PE_W-1:0] r_pe;
   logic [CF_W-1:0] r_cf;

   logic w_t_wrap;
   logic w_pe_wrap;
   logic w_cf_wrap;

   assign w_t_wrap  = (r_t == c_T_LAST);
   assign w_pe_wrap = (r_pe == c_PE_LAST);
   assign w_cf_wrap = (r_cf == c_CF_LAST);

   always_ff @(posedge clk) begin
      if (rst || i_clear) begin
         r_t  <= '0;
         r_pe <= '0;
         r_cf <= '0;
      end else if (i_advance) begin
         if (!w_t_wrap) begin
            r_t <= r_t + 1'b1;
         end else begin
            r_t <= '0;
            if (!w_pe_wrap) begin
               r_pe <= r_pe + 1'b1;
            end else begin
               r_pe <= '0;
               r_cf <= w_cf_wrap ? '0 : r_cf + 1'b1;
            end
         end
      end
   end

   assign o_last = w_t_wrap && w_pe_wrap && w_cf_wrap;
   assign o_addr = WORD_BITS'(compose_addr(int'(r_cf), int'(r_pe), int'(r_t), N, PE, CF));

endmodule
`default_nettype wire

// File: rtl/thresholding_cfg_loader.sv
`default_nettype none
// thresholding_cfg_loader: AXI4-Stream thresholds -> AXI4-Lite writes into a thresholding core (rev 1.0).
// Optional readback check per word when THRESHOLDING_CFG_LOADER_VERIFY_EN is defined.
module thresholding_cfg_loader
   import thresholding_cfg_pkg::*;
#(
   parameter  int N         = 4,
   parameter  int K         = 16,
   parameter  int C         = 6,
   parameter  int PE        = 2,
   parameter  int SIGNED    = 0,
   localparam int CF        = C / PE,
   localparam int ADDR_BITS = $clog2(CF) + $clog2(PE) + N + 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic                 err,
   output logic                 s_axis_tready,
   input  logic                 s_axis_tvalid,
   input  logic [K-1:0]         s_axis_tdata,
   output logic                 m_axilite_AWVALID,
   input  logic                 m_axilite_AWREADY,
   output logic [ADDR_BITS-1:0] m_axilite_AWADDR,
   output logic                 m_axilite_WVALID,
   input  logic                 m_axilite_WREADY,
   output logic [31:0]          m_axilite_WDATA,
   output logic [3:0]           m_axilite_WSTRB,
   input  logic                 m_axilite_BVALID,
   output logic                 m_axilite_BREADY,
   input  logic [1:0]           m_axilite_BRESP,
   output logic                 m_axilite_ARVALID,
   input  logic                 m_axilite_ARREADY,
   output logic [ADDR_BITS-1:0] m_axilite_ARADDR,
   input  logic                 m_axilite_RVALID,
   output logic                 m_axilite_RREADY,
   input  logic [31:0]          m_axilite_RDATA,
   input  logic [1:0]           m_axilite_RRESP
);

   localparam int WORD_BITS = ADDR_BITS - 2;

   state_t               r_state;
   state_t               w_next;
   logic                 r_awvalid;
   logic                 r_wvalid;
   logic                 r_err;
   logic [31:0]          r_wdata;
   logic [31:0]          w_ext;
   logic [WORD_BITS-1:0] w_addr;
   logic                 w_last;
   logic                 w_advance;
   logic                 w_set_err;
   logic                 w_start_ok;
   logic                 w_aw_ok;
   logic                 w_w_ok;

   thresholding_cfg_addr_gen #(
      .N         (N),
      .PE        (PE),
      .CF        (CF),
      .WORD_BITS (WORD_BITS)
   ) u_addr_gen (
      .clk       (clk),
      .rst       (rst),
      .i_clear   (w_start_ok),
      .i_advance (w_advance),
      .o_last    (w_last),
      .o_addr    (w_addr)
   );

   generate
      if (SIGNED != 0) begin : g_ext_signed
         assign w_ext = 32'($signed(s_axis_tdata));
      end else begin : g_ext_zero
         assign w_ext = 32'(s_axis_tdata);
      end
   endgenerate

   assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   assign w_aw_ok    = !r_awvalid || m_axilite_AWREADY;
   assign w_w_ok     = !r_wvalid  || m_axilite_WREADY;

`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
   logic r_arvalid;
   logic w_rready;
   logic w_rd_ok;
   logic w_unused_rd;

   // Read address goes first; data is accepted only once AR has completed.
   assign w_rready    = (r_state == ST_VERIFY) && !r_arvalid;
   assign w_rd_ok     = (m_axilite_RDATA[K-1:0] == r_wdata[K-1:0]) && (m_axilite_RRESP == c_OKAY);
   assign w_unused_rd = ^(m_axilite_RDATA >> K);
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{m_axilite_ARREADY, m_axilite_RVALID, m_axilite_RDATA, m_axilite_RRESP};
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_advance = 1'b0;
      w_set_err = 1'b0;
      case (r_state)
         ST_IDLE, ST_DONE: begin
            if (start) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            if (s_axis_tvalid) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (w_aw_ok && w_w_ok) w_next = ST_RESP;
         end
         ST_RESP: begin
            if (m_axilite_BVALID) begin
               if (m_axilite_BRESP != c_OKAY) begin
                  w_set_err = 1'b1;
                  w_next    = ST_DONE;
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
               end else begin
                  w_next = ST_VERIFY;
               end
`else
               end else if (w_last) begin
                  w_next = ST_DONE;
               end else begin
                  w_advance = 1'b1;
                  w_next    = ST_FETCH;
               end
`endif
            end
         end
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
         ST_VERIFY: begin
            if (w_rready && m_axilite_RVALID) begin
               if (!w_rd_ok) begin
                  w_set_err = 1'b1;
                  w_next    = ST_DONE;
               end else if (w_last) begin
                  w_next = ST_DONE;
               end else begin
                  w_advance = 1'b1;
                  w_next    = ST_FETCH;
               end
            end
         end
`endif
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_awvalid <= 1'b0;
         r_wvalid  <= 1'b0;
         r_wdata   <= '0;
         r_err     <= 1'b0;
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
         r_arvalid <= 1'b0;
`endif
      end else begin
         if (w_start_ok)     r_err <= 1'b0;
         else if (w_set_err) r_err <= 1'b1;

         // Each VALID falls independently once its own ready has been seen.
         if (r_state == ST_FETCH && s_axis_tvalid) begin
            r_wdata   <= w_ext;
            r_awvalid <= 1'b1;
            r_wvalid  <= 1'b1;
         end else begin
            if (r_awvalid && m_axilite_AWREADY) r_awvalid <= 1'b0;
            if (r_wvalid && m_axilite_WREADY)   r_wvalid  <= 1'b0;
         end
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
         if (r_state == ST_RESP && m_axilite_BVALID && m_axilite_BRESP == c_OKAY)
            r_arvalid <= 1'b1;
         else if (r_arvalid && m_axilite_ARREADY)
            r_arvalid <= 1'b0;
`endif
      end
   end

   assign busy              = (r_state != ST_IDLE) && (r_state != ST_DONE);
   assign done              = (r_state == ST_DONE);
   assign err               = r_err;
   assign s_axis_tready     = (r_state == ST_FETCH);
   assign m_axilite_AWVALID = r_awvalid;
   assign m_axilite_AWADDR  = {w_addr, 2'b00};
   assign m_axilite_WVALID  = r_wvalid;
   assign m_axilite_WDATA   = r_wdata;
   assign m_axilite_WSTRB   = 4'hF;
   assign m_axilite_BREADY  = (r_state == ST_RESP);
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
   assign m_axilite_ARVALID = r_arvalid;
   assign m_axilite_ARADDR  = {w_addr, 2'b00};
   assign m_axilite_RREADY  = w_rready;
`else
   assign m_axilite_ARVALID = 1'b0;
   assign m_axilite_ARADDR  = '0;
   assign m_axilite_RREADY  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_thresholding_cfg_loader.sv
`default_nettype none
// tb_thresholding_cfg_loader: directed checks of the loader against a behavioural AXI-Lite target.
`timescale 1ns/1ps
module tb_thresholding_cfg_loader;

   localparam int N = 4, K = 16, C = 6, PE = 2, AB = 9, NW = 90;
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
   localparam int WORD_CYC = 5;
   localparam int EXP_RD   = 90;
`else
   localparam int WORD_CYC = 3;
   localparam int EXP_RD   = 0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   always #5 clk = ~clk;

   logic busy, done, err, tready, awvalid, wvalid, bready, arvalid, rready;
   logic [AB-1:0] awaddr, araddr;
   logic [31:0] wdata;
   logic [3:0] wstrb;
   logic s_busy_unused, s_done_unused, s_err_unused, s_tready_unused, s_awvalid_unused;
   logic s_wvalid_unused, s_bready_unused, s_arvalid_unused, s_rready_unused;
   logic [AB-1:0] s_awaddr_unused, s_araddr_unused;
   logic [3:0] s_wstrb_unused;
   logic [31:0] s_wdata;

   logic tvalid, awready, wready, arready;
   logic [K-1:0] tdata;
   logic bvalid, rvalid;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;

   // bench configuration (driven only by the initial block)
   logic model_clr = 1'b0, rand_en = 1'b0, stream_const = 1'b0;
   int aw_wait = 0, err_word = -1, corrupt_word = -1;

   // target model state (driven only by the responder)
   int si, wr_cnt, aw_hs, rd_cnt, early4, drops, cyc, aw_cnt, t_aw, t_w;
   logic got_aw, got_w, aw_pend, w_pend, ar_pend, aw_rnd, w_rnd;
   logic [AB-1:0] lat_addr;
   logic [31:0] lat_data;
   logic [31:0] mem [128];
   int wcnt [128];

   int n_pass = 0, n_total = 0;

   logic a_hs, w_hs;
   int widx, ridx;
   logic [31:0] wval;

   assign tvalid  = 1'b1;
   assign tdata   = stream_const ? 16'hFFF6 : 16'(100 * (si / 15) + si % 15);
   assign awready = rand_en ? aw_rnd : (aw_cnt >= aw_wait);
   assign wready  = rand_en ? w_rnd : 1'b1;
   assign arready = 1'b1;
   assign rresp   = 2'b00;
   assign a_hs    = awvalid && awready;
   assign w_hs    = wvalid && wready;
   assign widx    = int'((got_aw ? lat_addr : awaddr) >> 2);
   assign wval    = got_w ? lat_data : wdata;
   assign ridx    = int'(araddr >> 2);

   thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(0)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
      .s_axis_tready(tready), .s_axis_tvalid(tvalid), .s_axis_tdata(tdata),
      .m_axilite_AWVALID(awvalid), .m_axilite_AWREADY(awready), .m_axilite_AWADDR(awaddr),
      .m_axilite_WVALID(wvalid), .m_axilite_WREADY(wready), .m_axilite_WDATA(wdata),
      .m_axilite_WSTRB(wstrb), .m_axilite_BVALID(bvalid), .m_axilite_BREADY(bready),
      .m_axilite_BRESP(bresp), .m_axilite_ARVALID(arvalid), .m_axilite_ARREADY(arready),
      .m_axilite_ARADDR(araddr), .m_axilite_RVALID(rvalid), .m_axilite_RREADY(rready),
      .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
   );

   thresholding_cfg_loader #(.N(N), .K(K), .C(C), .PE(PE), .SIGNED(1)) u_dut_s (
      .clk(clk), .rst(rst), .start(start), .busy(s_busy_unused), .done(s_done_unused),
      .err(s_err_unused), .s_axis_tready(s_tready_unused), .s_axis_tvalid(tvalid),
      .s_axis_tdata(tdata), .m_axilite_AWVALID(s_awvalid_unused), .m_axilite_AWREADY(awready),
      .m_axilite_AWADDR(s_awaddr_unused), .m_axilite_WVALID(s_wvalid_unused),
      .m_axilite_WREADY(wready), .m_axilite_WDATA(s_wdata), .m_axilite_WSTRB(s_wstrb_unused),
      .m_axilite_BVALID(bvalid), .m_axilite_BREADY(s_bready_unused), .m_axilite_BRESP(bresp),
      .m_axilite_ARVALID(s_arvalid_unused), .m_axilite_ARREADY(arready),
      .m_axilite_ARADDR(s_araddr_unused), .m_axilite_RVALID(rvalid),
      .m_axilite_RREADY(s_rready_unused), .m_axilite_RDATA(rdata), .m_axilite_RRESP(rresp)
   );

   // AXI-Lite target: memory, response injection, ready shaping and protocol monitor
   always @(posedge clk) begin
      cyc    <= cyc + 1;
      aw_rnd <= 1'($urandom_range(0, 1));
      w_rnd  <= 1'($urandom_range(0, 1));
      if (rst || model_clr) begin
         si <= 0; wr_cnt <= 0; aw_hs <= 0; rd_cnt <= 0; early4 <= 0; drops <= 0;
         aw_cnt <= 0; got_aw <= 1'b0; got_w <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
         rvalid <= 1'b0; rdata <= '0; aw_pend <= 1'b0; w_pend <= 1'b0; ar_pend <= 1'b0;
         if (model_clr) begin
            mem  <= '{default: 32'h0};
            wcnt <= '{default: 0};
         end
      end else begin
         if ((aw_pend && !awvalid) || (w_pend && !wvalid) || (ar_pend && !arvalid))
            drops <= drops + 1;
         aw_pend <= awvalid && !awready;
         w_pend  <= wvalid && !wready;
         ar_pend <= arvalid && !arready;
         if (awvalid) aw_cnt <= awready ? 0 : aw_cnt + 1;
         if (a_hs) begin got_aw <= 1'b1; lat_addr <= awaddr; t_aw <= cyc; aw_hs <= aw_hs + 1; end
         if (w_hs) begin got_w <= 1'b1; lat_data <= wdata; t_w <= cyc; end
         if ((got_aw || a_hs) && (got_w || w_hs)) begin
            mem[widx]  <= wval;
            wcnt[widx] <= wcnt[widx] + 1;
            wr_cnt     <= wr_cnt + 1;
            bvalid     <= 1'b1;
            bresp      <= (wr_cnt == err_word) ? 2'b10 : 2'b00;
            got_aw     <= 1'b0;
            got_w      <= 1'b0;
            if ((got_aw ? t_aw : cyc) - (got_w ? t_w : cyc) == 4) early4 <= early4 + 1;
         end
         if (bvalid && bready) bvalid <= 1'b0;
         if (tvalid && tready) si <= si + 1;
         if (arvalid && arready) begin
            rvalid <= 1'b1;
            rdata  <= mem[ridx] ^ ((ridx == corrupt_word) ? 32'h1 : 32'h0);
            rd_cnt <= rd_cnt + 1;
         end
         if (rvalid && rready) rvalid <= 1'b0;
      end
   end

   function automatic int scan_bad();
      int bad = 0;
      for (int c = 0; c < C; c++)
         for (int t = 0; t < 15; t++) begin
            int w = t + (c % 2) * 16 + (c / 2) * 32;
            if (mem[w] !== 32'(100 * c + t) || wcnt[w] != 1) bad++;
         end
      return bad;
   endfunction

   task automatic clr_model();
      model_clr = 1'b1; @(posedge clk); #1; model_clr = 1'b0;
   endtask

   task automatic start_pass();
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
   endtask

   task automatic wait_done(input int c0, input int limit, output int cycles);
      cycles = c0;
      while (done !== 1'b1 && cycles < limit) begin @(posedge clk); #1; cycles++; end
      n_total++;
      if (done !== 1'b1) $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, cycles);
      else n_pass++;
   endtask

   task automatic wait_awvalid(input int limit);
      int k = 0;
      while (awvalid !== 1'b1 && k < limit) begin @(posedge clk); #1; k++; end
      n_total++;
      if (awvalid !== 1'b1) $display("FAIL awvalid_timeout: awvalid=%b, required 1", awvalid);
      else n_pass++;
   endtask

   task automatic test_reset();
      logic [8:0] flags;
      repeat (3) @(posedge clk);
      #1;
      flags = {busy, done, err, tready, awvalid, wvalid, bready, arvalid, rready};
      n_total++; if (flags !== 9'h0) $display("FAIL reset_flags: got %b, required 0", flags); else n_pass++;
      n_total++; if (awaddr !== '0) $display("FAIL reset_awaddr: got %h, required 0", awaddr); else n_pass++;
      n_total++; if (wdata !== '0) $display("FAIL reset_wdata: got %h, required 0", wdata); else n_pass++;
      n_total++; if (araddr !== '0) $display("FAIL reset_araddr: got %h, required 0", araddr); else n_pass++;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_total++; if ({busy, done} !== 2'b00) $display("FAIL idle_flags: busy/done %b, required 00", {busy, done}); else n_pass++;
   endtask

   task automatic test_full_pass();
      int cycles, bad;
      clr_model();
      start_pass();
      n_total++; if (busy !== 1'b1) $display("FAIL busy_after_start: got %b, required 1", busy); else n_pass++;
      repeat (10) @(posedge clk);
      #1;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      wait_done(11, 2000, cycles);
      n_total++; if (cycles != NW * WORD_CYC) $display("FAIL pass_cycles: got %0d, required %0d", cycles, NW * WORD_CYC); else n_pass++;
      n_total++; if (wr_cnt != NW) $display("FAIL pass_writes: got %0d, required %0d", wr_cnt, NW); else n_pass++;
      n_total++; if (mem[53] !== 32'd305) $display("FAIL word_c3_t5: got %0d at 0xD4, required 305", mem[53]); else n_pass++;
      bad = scan_bad();
      n_total++; if (bad != 0) $display("FAIL pass_contents: %0d bad words, required 0", bad); else n_pass++;
      n_total++; if (rd_cnt != EXP_RD) $display("FAIL pass_reads: got %0d, required %0d", rd_cnt, EXP_RD); else n_pass++;
      repeat (5) @(posedge clk);
      #1;
      n_total++; if ({done, busy, err} !== 3'b100) $display("FAIL done_level: done/busy/err %b, required 100", {done, busy, err}); else n_pass++;
   endtask

   task automatic test_skew();
      int cycles, bad;
      clr_model();
      aw_wait = 4;
      start_pass();
      wait_done(0, 5000, cycles);
      bad = scan_bad();
      n_total++; if (bad != 0) $display("FAIL skew4_contents: %0d bad words, required 0", bad); else n_pass++;
      n_total++; if (early4 != NW) $display("FAIL skew4_w_lead: got %0d words, required %0d", early4, NW); else n_pass++;
      n_total++; if (drops != 0) $display("FAIL skew4_valid_drop: got %0d, required 0", drops); else n_pass++;
      aw_wait = 0;
      rand_en = 1'b1;
      clr_model();
      start_pass();
      wait_done(0, 20000, cycles);
      bad = scan_bad();
      n_total++; if (bad != 0) $display("FAIL rand_contents: %0d bad words, required 0", bad); else n_pass++;
      n_total++; if (drops != 0) $display("FAIL rand_valid_drop: got %0d, required 0", drops); else n_pass++;
      n_total++; if (err !== 1'b0) $display("FAIL rand_err: got %b, required 0", err); else n_pass++;
      rand_en = 1'b0;
   endtask

   task automatic test_bresp_err();
      int cycles;
      clr_model();
      err_word = 17;
      start_pass();
      wait_done(0, 2000, cycles);
      n_total++; if (err !== 1'b1) $display("FAIL bresp_err_flag: got %b, required 1", err); else n_pass++;
      n_total++; if (si != 18) $display("FAIL bresp_consumed: got %0d words, required 18", si); else n_pass++;
      repeat (10) @(posedge clk);
      #1;
      n_total++; if (aw_hs != 18 || awvalid !== 1'b0) $display("FAIL bresp_no_more_aw: aw=%0d awvalid=%b, required 18/0", aw_hs, awvalid); else n_pass++;
      n_total++; if ({done, tready} !== 2'b10) $display("FAIL bresp_done: done/tready %b, required 10", {done, tready}); else n_pass++;
      err_word = -1;
   endtask

   task automatic test_signed();
      int cycles;
      clr_model();
      stream_const = 1'b1;
      start_pass();
      n_total++; if (err !== 1'b0) $display("FAIL start_clears_err: got %b, required 0", err); else n_pass++;
      wait_awvalid(10);
      n_total++; if (wdata !== 32'h0000FFF6) $display("FAIL zero_ext: got %h, required 0000fff6", wdata); else n_pass++;
      n_total++; if (s_wdata !== 32'hFFFFFFF6) $display("FAIL sign_ext: got %h, required fffffff6", s_wdata); else n_pass++;
      wait_done(0, 2000, cycles);
      stream_const = 1'b0;
   endtask

   task automatic test_rst_mid();
      int k = 0, cycles, bad;
      clr_model();
      start_pass();
      while (!(bready === 1'b1 && wr_cnt == 41) && k < 1000) begin @(posedge clk); #1; k++; end
      n_total++; if (!(bready === 1'b1 && wr_cnt == 41)) $display("FAIL resp_word40_reached: bready=%b writes=%0d, required 1/41", bready, wr_cnt); else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      n_total++; if ({busy, done, err, awvalid, bready} !== 5'b0) $display("FAIL mid_reset_flags: got %b, required 0", {busy, done, err, awvalid, bready}); else n_pass++;
      rst = 1'b0;
      clr_model();
      start_pass();
      wait_awvalid(10);
      n_total++; if (awaddr !== 9'h000 || err !== 1'b0) $display("FAIL restart_addr: awaddr=%h err=%b, required 000/0", awaddr, err); else n_pass++;
      wait_done(0, 2000, cycles);
      bad = scan_bad();
      n_total++; if (bad != 0 || wr_cnt != NW) $display("FAIL restart_contents: bad=%0d writes=%0d, required 0/%0d", bad, wr_cnt, NW); else n_pass++;
   endtask

`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
   task automatic test_verify_corrupt();
      int cycles;
      clr_model();
      corrupt_word = 94;
      start_pass();
      wait_done(0, 2000, cycles);
      n_total++; if (err !== 1'b1) $display("FAIL verify_err: got %b, required 1", err); else n_pass++;
      n_total++; if (rd_cnt != 90 || wr_cnt != 90) $display("FAIL verify_counts: reads=%0d writes=%0d, required 90/90", rd_cnt, wr_cnt); else n_pass++;
      corrupt_word = -1;
   endtask
`endif

   initial begin
      test_reset();
      test_full_pass();
      test_skew();
      test_bresp_err();
      test_signed();
      test_rst_mid();
`ifdef THRESHOLDING_CFG_LOADER_VERIFY_EN
      test_verify_corrupt();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
